// File: rtl/nice_stream_broadcaster.sv
// nice_stream_broadcaster: copies each accepted input beat into per-channel
// FIFOs selected by in_mask. Each channel drains on its own valid/ready
// handshake. Lossless mode backpressures on any full destination; lossy mode
// always accepts and counts the beats a full channel could not take.
module nice_stream_broadcaster #(
    parameter int DATA_W       = 32,
    parameter int NUM_OUT      = 4,
    parameter int DEPTH        = 2,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic [NUM_OUT-1:0]                     in_mask,
    output logic [NUM_OUT-1:0]                     out_valid,
    input  logic [NUM_OUT-1:0]                     out_ready,
    output logic [NUM_OUT*DATA_W-1:0]              out_data,
    output logic [NUM_OUT*($clog2(DEPTH)+1)-1:0]   out_level,
    output logic [NUM_OUT*CNT_W-1:0]               drop_cnt,
    input  logic                                   drop_clr,
    output logic                                   idle
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam bit LOSSY = (DROP_ON_FULL != 0);

    // Saturating increment for the drop counters: holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic [NUM_OUT-1:0] ch_ok;
    logic               accept;

    // in_ready only looks at registered occupancy plus the beat's own mask,
    // so out_ready never reaches it combinationally.
    assign in_ready = !rst && (LOSSY || (&ch_ok));
    assign accept   = in_valid && in_ready;
    assign idle     = ~|out_valid;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_ch
        logic [PTR_W-1:0]  rd_ptr;
        logic [PTR_W-1:0]  wr_ptr;
        logic [LVL_W-1:0]  count;
        logic [DATA_W-1:0] mem [DEPTH];
        logic [CNT_W-1:0]  drops;
        logic              full;
        logic              push;
        logic              pop;
        logic              drop_event;

        // Fullness is judged before this cycle's pop: a full channel being
        // drained in the same cycle still refuses the new beat.
        assign full       = (count == FULL_LVL);
        assign ch_ok[i]   = !in_mask[i] || !full;
        assign push       = accept && in_mask[i] && !full;
        assign pop        = (count != '0) && out_ready[i];
        assign drop_event = LOSSY && accept && in_mask[i] && full;

        assign out_valid[i]                   = (count != '0);
        assign out_data[i*DATA_W +: DATA_W]   = mem[rd_ptr];
        assign out_level[i*LVL_W +: LVL_W]    = count;
        assign drop_cnt[i*CNT_W +: CNT_W]     = drops;

        // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + LVL_W'(1);
                    2'b01:   count <= count - LVL_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // Payload storage carries no reset; stale entries are never visible
        // because out_valid follows the registered count.
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= in_data;
            end
        end

        // Drop counter: clear beats a simultaneous drop. In lossless builds
        // drop_event is constant 0 so the register stays at zero.
        always_ff @(posedge clk) begin
            if (rst || drop_clr) begin
                drops <= '0;
            end else if (drop_event) begin
                drops <= sat_inc(drops);
            end
        end
    end

endmodule

// File: doc/nice_stream_broadcaster.md
Name: nice_stream_broadcaster

Overview:
Synthesisable RTL stream broadcaster. It copies each accepted input beat to up to NUM_OUT output channels using valid/ready handshakes. Each channel has its own FIFO, so a slow consumer does not stall the others until that channel's FIFO fills. It is the parametrised hardware successor to the components broadcaster utility, and adds per-beat destination masks, a lossy drop-on-full mode with saturating drop counters, and per-channel occupancy reporting.

Parameters:
DATA_W, 32, payload width in bits (>=1)
NUM_OUT, 4, number of output channels (1..32)
DEPTH, 2, per-channel FIFO depth; power of two, >=2
DROP_ON_FULL, 0, 0 = lossless (backpressure), 1 = lossy (drop beats at full channels)
CNT_W, 16, drop counter width
LVL_W, $clog2(DEPTH)+1, derived occupancy width; not overridable

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  DATA_W  input payload
in_mask  in  NUM_OUT  destination enable per channel; sampled with the beat
out_valid  out  NUM_OUT  per-channel valid
out_ready  in  NUM_OUT  per-channel ready
out_data  out  NUM_OUT*DATA_W  per-channel payload; channel i is at [i*DATA_W +: DATA_W]
out_level  out  NUM_OUT*LVL_W  per-channel FIFO occupancy
drop_cnt  out  NUM_OUT*CNT_W  per-channel dropped-beat count (lossy mode only)
drop_clr  in  1  synchronous clear of all drop counters
idle  out  1  high when all FIFOs are empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0 during the rst cycle, then as defined below. out_valid=0, out_level=0, drop_cnt=0, idle=1. FIFO contents are don't-care.
- Reset mid-operation: all queued beats are discarded. An input handshake in the same cycle as rst is ignored.
- Per-channel FIFO:
  - Circular buffer with rd/wr pointers of width $clog2(DEPTH) and a count of width LVL_W.
  - Pointers wrap modulo DEPTH.
  - out_valid[i] = (count_i != 0).
  - out_data[i] is the head entry, driven from registers.
- Latency: a beat accepted in cycle N appears as out_valid in cycle N+1, minimum. There is no combinational path from in_* to out_*.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.
  - Lossless mode: in_ready = AND over i of (!in_mask[i] || count_i < DEPTH). in_mask is the only combinational input to in_ready.
  - Lossy mode: in_ready = 1 whenever not in reset.
- Push on accept: channel i is written iff in_mask[i] and count_i < DEPTH, evaluated before this cycle's pop.
  - A full FIFO that is popped in the same cycle still rejects the push.
- Drops (lossy mode only): on accept with in_mask[i] set and count_i == DEPTH, the beat is dropped for channel i only. drop_cnt[i] increments and saturates at 2^CNT_W-1. Other channels still receive the beat.
- Mask all zero: the beat is accepted (in_ready=1 in both modes) and discarded. No counters change.
- Pop: when out_valid[i] && out_ready[i], the head advances.
- Simultaneous push and pop on a non-full, non-empty channel: count is unchanged and both pointers advance.
- Simultaneous push and pop on an empty channel: the pushed beat is not visible until the next cycle. There is no bypass.
- Ordering: within each channel, beats leave in acceptance order. There is no ordering relation across channels.
- drop_clr: drop_cnt resets to 0 on the next edge. If a drop occurs in the same cycle, clear wins and the result is 0.
- In lossless mode, drop_cnt is tied to 0 and drop_clr is ignored.
- idle = AND over i of (count_i == 0), registered-derived.
- Handshake rules:
  - The upstream may not retract in_valid or change in_data/in_mask while in_valid && !in_ready. The block does not check this.
  - The block never drops out_valid before the handshake completes.

Test Plan:
- Fan-out: NUM_OUT=4, DEPTH=2, lossless. Send 0xA5 with mask 4'b1111 and all out_ready=1 -> out_valid=4'b1111 at N+1 with 0xA5 on every channel. idle=0 at N+1 and idle=1 at N+2.
- Backpressure: lossless. Hold out_ready[2]=0 and send 0x01,0x02,0x03 with mask 4'hF -> in_ready=0 after 2 accepts and out_level[2]=2. Release out_ready[2] -> 0x03 is accepted. Channel 2 delivers 0x01,0x02,0x03 in order.
- Masking: send 0x10 with mask 4'b0101 -> only channels 0 and 2 output 0x10. Send mask 4'b0000 -> beat accepted, no outputs, idle stays 1.
- Lossy: DROP_ON_FULL=1, out_ready[1]=0, send 5 beats with mask 4'hF -> in_ready stays 1, drop_cnt[1]=3, other channels receive all 5 beats. Pulse drop_clr -> drop_cnt[1]=0.
- Saturation and wrap: CNT_W=2, DEPTH=2. Force 6 drops -> drop_cnt=3. Stream 20 beats through one channel with out_ready toggling 1,0 -> data matches the scoreboard across pointer wraparound.
- Reset mid-stream: assert rst with out_level=2 on all channels -> the next cycle has out_valid=0, out_level=0, idle=1, drop_cnt=0, and no stale beats emerge afterwards.
